// File: rtl/norm_shift8_pipe.sv
// norm_shift8_pipe
//
// Two-stage pipelined normalizer for an 8-bit mantissa with a biased,
// unsigned exponent. The mantissa is shifted left until its MSB is set,
// and the exponent is reduced by the same amount. The exponent never goes
// below zero: when the leading-zero count exceeds the exponent, the shift
// is clamped to the exponent and the result is flagged as denormal
// (uflow_out). An all-zero mantissa gives a canonical zero result.
//
// Stage S1 registers the operand together with its leading-zero count.
// Stage S2 applies the clamped shift and drives the outputs directly.
// Both stages use valid/ready handshaking, so a full pipe can take a new
// operand in the same cycle that it hands one downstream.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   upstream holds a valid operand
//   in_ready   operand is accepted this cycle (combinational from out_ready)
//   mant_in    unnormalized mantissa, bit 7 is the MSB
//   exp_in     biased exponent of mant_in
//   out_valid  result registers hold a valid result
//   out_ready  downstream accepts the result this cycle
//   mant_out   normalized mantissa
//   exp_out    adjusted exponent
//   zero_out   the operand mantissa was zero
//   uflow_out  shift was clamped by the exponent (denormal result)

module norm_shift8_pipe #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       mant_in,
    input  logic [EXP_W-1:0] exp_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       mant_out,
    output logic [EXP_W-1:0] exp_out,
    output logic             zero_out,
    output logic             uflow_out
);

    // Compare width wide enough for both the 3-bit count and the exponent.
    localparam int CW = (EXP_W > 3) ? EXP_W : 3;

    // Stage S1 state
    logic             s1_valid;
    logic [7:0]       s1_mant;
    logic [EXP_W-1:0] s1_exp;
    logic [2:0]       s1_lz;
    logic             s1_zero;

    // Stage S2 valid; S2 data lives in the output registers themselves
    logic             s2_valid;

    // Handshake / advance conditions
    logic             s2_adv;
    logic             s1_adv;

    // Combinational next values
    logic [2:0]       lz_in;
    logic [CW-1:0]    lz_ext;
    logic [CW-1:0]    exp_ext;
    logic             clamp;
    logic [2:0]       sh;
    logic [7:0]       mant_nxt;
    logic [EXP_W-1:0] exp_nxt;
    logic             uflow_nxt;

    // S2 moves when empty or when its result leaves; S1 moves when empty or
    // when S2 moves. Because out_valid is S2's valid, a transfer out only
    // needs out_ready once S2 is known full.
    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Leading-zero count of the incoming mantissa. 0x01 and 0x00 both
    // saturate at 7; zero is handled separately through s1_zero.
    always_comb begin
        lz_in = 3'd7;
        casez (mant_in)
            8'b1???????: lz_in = 3'd0;
            8'b01??????: lz_in = 3'd1;
            8'b001?????: lz_in = 3'd2;
            8'b0001????: lz_in = 3'd3;
            8'b00001???: lz_in = 3'd4;
            8'b000001??: lz_in = 3'd5;
            8'b0000001?: lz_in = 3'd6;
            default:     lz_in = 3'd7;
        endcase
    end

    // Clamped shift for S2. When the count exceeds the exponent the
    // exponent is below 7, so its low three bits are the full shift amount
    // and the resulting exponent is exactly zero.
    always_comb begin
        lz_ext    = CW'(s1_lz);
        exp_ext   = CW'(s1_exp);
        clamp     = lz_ext > exp_ext;
        sh        = clamp ? exp_ext[2:0] : s1_lz;
        mant_nxt  = s1_mant << sh;
        exp_nxt   = s1_exp - EXP_W'(sh);
        uflow_nxt = clamp;
        if (s1_zero) begin
            mant_nxt  = 8'h00;
            exp_nxt   = '0;
            uflow_nxt = 1'b0;
        end
    end

    // Pipeline registers. Data only loads on a stage advance; when the
    // matching valid is low the data contents are meaningless.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            mant_out  <= 8'h00;
            exp_out   <= '0;
            zero_out  <= 1'b0;
            uflow_out <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                s1_mant  <= mant_in;
                s1_exp   <= exp_in;
                s1_lz    <= lz_in;
                s1_zero  <= (mant_in == 8'h00);
            end
            if (s2_adv) begin
                s2_valid  <= s1_valid;
                mant_out  <= mant_nxt;
                exp_out   <= exp_nxt;
                zero_out  <= s1_zero;
                uflow_out <= uflow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_norm_shift8_pipe.sv
// tb_norm_shift8_pipe
//
// Bench for norm_shift8_pipe. Two instances share clock, reset and
// handshake stimulus: one with an 8-bit exponent and one with a 5-bit
// exponent (which sees the low five bits of the driven exponent).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_norm_shift8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] mant_in;
    logic [7:0] exp_in8;
    logic [4:0] exp_in5;
    logic       out_ready;

    logic       in_ready8, out_valid8, zero_out8, uflow_out8;
    logic [7:0] mant_out8, exp_out8;
    logic       in_ready5, out_valid5, zero_out5, uflow_out5;
    logic [7:0] mant_out5;
    logic [4:0] exp_out5;

    int tests    = 0;
    int failures = 0;

    // Observed result bundles: {valid, mant, exp, uflow, zero}
    wire [18:0] obs8 = {out_valid8, mant_out8, exp_out8, uflow_out8, zero_out8};
    wire [15:0] obs5 = {out_valid5, mant_out5, exp_out5, uflow_out5, zero_out5};

    always #5 clk = ~clk;

    norm_shift8_pipe #(.EXP_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready8),
        .mant_in(mant_in), .exp_in(exp_in8),
        .out_valid(out_valid8), .out_ready(out_ready),
        .mant_out(mant_out8), .exp_out(exp_out8),
        .zero_out(zero_out8), .uflow_out(uflow_out8)
    );

    norm_shift8_pipe #(.EXP_W(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready5),
        .mant_in(mant_in), .exp_in(exp_in5),
        .out_valid(out_valid5), .out_ready(out_ready),
        .mant_out(mant_out5), .exp_out(exp_out5),
        .zero_out(zero_out5), .uflow_out(uflow_out5)
    );

    // Advance one clock: through the rising edge to the next falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] m, input logic [7:0] e);
        in_valid = v;
        mant_in  = m;
        exp_in8  = e;
        exp_in5  = e[4:0];
    endtask

    // Reference normalizer: shift one bit at a time while the MSB is clear
    // and the exponent is still positive.
    function automatic void norm_ref(input logic [7:0] m, input int e,
                                     output logic [7:0] mo, output int eo,
                                     output logic u, output logic z);
        logic [7:0] mm = m;
        int ee = e;
        if (m == 8'h00) begin
            mo = 8'h00; eo = 0; u = 1'b0; z = 1'b1;
        end else begin
            while (!mm[7] && ee > 0) begin
                mm = mm << 1;
                ee = ee - 1;
            end
            mo = mm; eo = ee; u = !mm[7]; z = 1'b0;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 8'h00);
        out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        tests++;
        if (obs8 !== 19'd0) begin
            failures++;
            $display("[TB] FAIL reset_state8 got %h expected %h", obs8, 19'd0);
        end
        tests++;
        if (obs5 !== 16'd0) begin
            failures++;
            $display("[TB] FAIL reset_state5 got %h expected %h", obs5, 16'd0);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({out_valid8, in_ready8, out_valid5, in_ready5} !== 4'b0101) begin
            failures++;
            $display("[TB] FAIL reset_release got %b expected %b",
                     {out_valid8, in_ready8, out_valid5, in_ready5}, 4'b0101);
        end
    endtask

    task automatic test_latency();
        out_ready = 1'b1;
        drive(1'b1, 8'h13, 8'd10);
        #1;
        tests++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL latency_in_ready got %b expected 1", in_ready8);
        end
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tests++;
        if ({out_valid8, out_valid5} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL latency_early got %b expected 00", {out_valid8, out_valid5});
        end
        tick();
        tests++;
        if (obs8 !== {1'b1, 8'h98, 8'd7, 2'b00}) begin
            failures++;
            $display("[TB] FAIL latency_result8 got %h expected %h", obs8, {1'b1, 8'h98, 8'd7, 2'b00});
        end
        tests++;
        if (obs5 !== {1'b1, 8'h98, 5'd7, 2'b00}) begin
            failures++;
            $display("[TB] FAIL latency_result5 got %h expected %h", obs5, {1'b1, 8'h98, 5'd7, 2'b00});
        end
        tick();
        tests++;
        if (out_valid8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_single got %b expected 0", out_valid8);
        end
    endtask

    // Consecutive operands with out_ready held high: in_ready never drops
    // and one result emerges per cycle, two cycles behind its input.
    task automatic test_back_to_back();
        logic [7:0] vm [7] = '{8'h13, 8'h00, 8'h04, 8'hFF, 8'h01, 8'h02, 8'h40};
        logic [7:0] ve [7] = '{8'd10, 8'd20, 8'd2, 8'd0, 8'd3, 8'd6, 8'd0};
        logic [7:0] rm [7] = '{8'h98, 8'h00, 8'h10, 8'hFF, 8'h08, 8'h80, 8'h40};
        logic [7:0] re [7] = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        logic       ru [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       rz [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [4:0] re5;
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 7) drive(1'b1, vm[c], ve[c]);
            else       drive(1'b0, 8'h00, 8'h00);
            #1;
            if (c < 7) begin
                tests++;
                if (in_ready8 !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL b2b_in_ready[%0d] got %b expected 1", c, in_ready8);
                end
            end
            if (c >= 2) begin
                re5 = re[c-2][4:0];
                tests++;
                if (obs8 !== {1'b1, rm[c-2], re[c-2], ru[c-2], rz[c-2]}) begin
                    failures++;
                    $display("[TB] FAIL b2b_result8[%0d] got %h expected %h", c - 2, obs8,
                             {1'b1, rm[c-2], re[c-2], ru[c-2], rz[c-2]});
                end
                tests++;
                if (obs5 !== {1'b1, rm[c-2], re5, ru[c-2], rz[c-2]}) begin
                    failures++;
                    $display("[TB] FAIL b2b_result5[%0d] got %h expected %h", c - 2, obs5,
                             {1'b1, rm[c-2], re5, ru[c-2], rz[c-2]});
                end
            end
            tick();
        end
        tests++;
        if (out_valid8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_drained got %b expected 0", out_valid8);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 8'h80, 8'd5);
        #1;
        tests++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_accept0 got %b expected 1", in_ready8);
        end
        tick();
        drive(1'b1, 8'h40, 8'd5);
        #1;
        tests++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_accept1 got %b expected 1", in_ready8);
        end
        tick();
        drive(1'b1, 8'h01, 8'd9);
        for (int k = 0; k < 4; k++) begin
            #1;
            tests++;
            if ({in_ready8, in_ready5} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL stall_in_ready[%0d] got %b expected 00", k, {in_ready8, in_ready5});
            end
            tests++;
            if (obs8 !== {1'b1, 8'h80, 8'd5, 2'b00}) begin
                failures++;
                $display("[TB] FAIL stall_hold8[%0d] got %h expected %h", k, obs8, {1'b1, 8'h80, 8'd5, 2'b00});
            end
            tests++;
            if (obs5 !== {1'b1, 8'h80, 5'd5, 2'b00}) begin
                failures++;
                $display("[TB] FAIL stall_hold5[%0d] got %h expected %h", k, obs5, {1'b1, 8'h80, 5'd5, 2'b00});
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready8 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_release_ready got %b expected 1", in_ready8);
        end
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tests++;
        if (obs8 !== {1'b1, 8'h80, 8'd4, 2'b00}) begin
            failures++;
            $display("[TB] FAIL stall_order1 got %h expected %h", obs8, {1'b1, 8'h80, 8'd4, 2'b00});
        end
        tick();
        tests++;
        if (obs8 !== {1'b1, 8'h80, 8'd2, 2'b00}) begin
            failures++;
            $display("[TB] FAIL stall_order2 got %h expected %h", obs8, {1'b1, 8'h80, 8'd2, 2'b00});
        end
        tick();
        tests++;
        if (out_valid8 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_drained got %b expected 0", out_valid8);
        end
    endtask

    // Exponent beyond the 5-bit range: the narrow instance sees 200 mod 32 = 8
    task automatic test_wide_exp();
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 8'd200);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        tick();
        tests++;
        if (obs8 !== {1'b1, 8'h80, 8'd193, 2'b00}) begin
            failures++;
            $display("[TB] FAIL wide_exp8 got %h expected %h", obs8, {1'b1, 8'h80, 8'd193, 2'b00});
        end
        tests++;
        if (obs5 !== {1'b1, 8'h80, 5'd1, 2'b00}) begin
            failures++;
            $display("[TB] FAIL wide_exp5 got %h expected %h", obs5, {1'b1, 8'h80, 5'd1, 2'b00});
        end
        tick();
    endtask

    // Reset with both stages full must discard everything
    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 8'h13, 8'd10);
        tick();
        drive(1'b1, 8'h04, 8'd2);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        #1;
        tests++;
        if ({out_valid8, in_ready8} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL rstmid_full got %b expected 10", {out_valid8, in_ready8});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tests++;
        if (obs8 !== 19'd0) begin
            failures++;
            $display("[TB] FAIL rstmid_clear8 got %h expected %h", obs8, 19'd0);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if ({out_valid8, out_valid5} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL rstmid_stale[%0d] got %b expected 00", k, {out_valid8, out_valid5});
            end
            tick();
        end
    endtask

    // Random handshaking against the reference normalizer
    task automatic test_random();
        logic [17:0] q8 [$];
        logic [14:0] q5 [$];
        logic [17:0] e8;
        logic [14:0] e5;
        logic [7:0]  mo;
        logic        u, z;
        int          eo;
        int          acc8 = 0;
        int          acc5 = 0;
        int          cyc  = 0;
        logic [7:0]  m, e;
        while ((acc8 < 10000 || q8.size() > 0 || q5.size() > 0) && cyc < 60000) begin
            m = 8'($urandom_range(255) >> $urandom_range(7));
            e = 8'($urandom_range(255));
            drive((acc8 < 10000) && ($urandom_range(3) != 0), m, e);
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (in_valid && in_ready8) begin
                norm_ref(m, int'(e), mo, eo, u, z);
                q8.push_back({mo, 8'(eo), u, z});
                acc8++;
            end
            if (in_valid && in_ready5) begin
                norm_ref(m, int'(e[4:0]), mo, eo, u, z);
                q5.push_back({mo, 5'(eo), u, z});
                acc5++;
            end
            if (out_valid8 && out_ready) begin
                tests++;
                if (q8.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand_extra8 got %h expected no result", obs8);
                end else begin
                    e8 = q8.pop_front();
                    if (obs8[17:0] !== e8) begin
                        failures++;
                        $display("[TB] FAIL rand_result8 got %h expected %h", obs8[17:0], e8);
                    end
                end
            end
            if (out_valid5 && out_ready) begin
                tests++;
                if (q5.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand_extra5 got %h expected no result", obs5);
                end else begin
                    e5 = q5.pop_front();
                    if (obs5[14:0] !== e5) begin
                        failures++;
                        $display("[TB] FAIL rand_result5 got %h expected %h", obs5[14:0], e5);
                    end
                end
            end
            tick();
            cyc++;
        end
        drive(1'b0, 8'h00, 8'h00);
        tests++;
        if (acc8 != 10000 || acc5 != 10000 || q8.size() != 0 || q5.size() != 0) begin
            failures++;
            $display("[TB] FAIL rand_count got acc8=%0d acc5=%0d left8=%0d left5=%0d expected 10000/10000/0/0",
                     acc8, acc5, q8.size(), q5.size());
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        test_reset();
        test_latency();
        test_back_to_back();
        test_stall();
        test_wide_exp();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
